dpe_mux_scheduler: RTL and testbench

- Packet-level arbiter that decides which of the five DPE ingress streams owns the dpe_multiplexer output: CPU (index 0) and ETH1..ETH4 (indices 1..4).
- Grants whole packets only and never switches mid-packet.
- Uses round-robin with a per-turn packet burst quota.
- Honours the pipeline pause request and reports idle to the DPE control logic.
- Sits beside the multiplexer datapath. Its one-hot grant drives the datapath select and per-input tready gating.

---
 rtl/dpe_pkg.sv | 25 ++
 rtl/dpe_rr_pick.sv | 40 ++++
 rtl/dpe_mux_scheduler.sv | 125 ++++++++++++
 tb/tb_dpe_mux_scheduler.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpe_pkg.sv
// Shared DPE definitions: requester count, source indices and common types.
package dpe_pkg;

  localparam int DPE_NUM_IN = 5;

  typedef logic [2:0]            dpe_src_t;
  typedef logic [DPE_NUM_IN-1:0] dpe_grant_t;

  localparam dpe_src_t DPE_SRC_CPU  = 3'd0;
  localparam dpe_src_t DPE_SRC_ETH1 = 3'd1;
  localparam dpe_src_t DPE_SRC_ETH2 = 3'd2;
  localparam dpe_src_t DPE_SRC_ETH3 = 3'd3;
  localparam dpe_src_t DPE_SRC_ETH4 = 3'd4;

  typedef enum logic {
    SCHED_IDLE = 1'b0,
    SCHED_BUSY = 1'b1
  } sched_state_t;

  // Next index in the circular order, wrapping n-1 back to 0.
  function automatic dpe_src_t dpe_next_src(input dpe_src_t s, input int n);
    return (int'(s) == n - 1) ? DPE_SRC_CPU : s + 3'd1;
  endfunction

endpackage

// File: rtl/dpe_rr_pick.sv
// Combinational circular priority picker: first set bit of req at or after
// start, wrapping around. Shared by the DPE arbiters.
module dpe_rr_pick
  import dpe_pkg::*;
#(
  parameter int N  = DPE_NUM_IN,
  parameter int IW = $bits(dpe_src_t)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] shifted;
  logic [N-1:0]   rot;
  logic [IW-1:0]  off;
  logic [IW:0]    sum;

  // Rotate the doubled request vector so start lands at bit 0, then take the
  // lowest set bit and map its offset back to an absolute index.
  always_comb begin
    // NOTE: every output and temporary gets a default first so no latch is inferred.
    off     = '0;
    dbl     = {req, req};
    shifted = dbl >> start;
    rot     = shifted[N-1:0];
    any     = |rot;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = IW'(i);
    end
    sum = {1'b0, start} + {1'b0, off};
    if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
    idx    = sum[IW-1:0];
    onehot = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/dpe_mux_scheduler.sv
// Packet-level round-robin scheduler for the DPE ingress multiplexer. Grants
// whole packets, allows up to BURST back-to-back packets per turn, honours
// pause at packet boundaries and flags packets longer than MAX_BEATS beats.
module dpe_mux_scheduler
  import dpe_pkg::*;
#(
  parameter int NUM_IN    = DPE_NUM_IN,
  parameter int BURST     = 2,
  parameter int MAX_BEATS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IN-1:0] req,
  input  logic              out_hs,
  input  logic              out_last,
  input  logic              pause,
  output logic [NUM_IN-1:0] grant,
  output dpe_src_t          grant_idx,
  output logic              grant_vld,
  output logic              is_idle,
  output logic              wdog_err
);

  localparam int BW = $clog2(MAX_BEATS) + 1;
  localparam logic [BW-1:0] BEAT_LIMIT = BW'(MAX_BEATS);
  localparam logic [BW-1:0] BEAT_ONE   = BW'(1);
  localparam logic [3:0]    BURST_Q    = 4'(BURST);

  sched_state_t      state;
  dpe_src_t          rr_ptr;
  logic [3:0]        burst_cnt;
  logic [BW-1:0]     beat_cnt;

  dpe_src_t          owner_nxt;
  dpe_src_t          pick_start;
  logic [NUM_IN-1:0] pick_onehot;
  dpe_src_t          pick_idx;
  logic              pick_any;
  logic              owner_req;
  logic              pkt_end;
  logic [BW-1:0]     beat_inc;

  // Arbitration start point and per-cycle packet status.
  always_comb begin
    owner_nxt  = dpe_next_src(grant_idx, NUM_IN);
    pick_start = (state == SCHED_BUSY) ? owner_nxt : rr_ptr;
    owner_req  = |(req & grant);
    pkt_end    = out_hs & out_last;
    beat_inc   = (&beat_cnt) ? beat_cnt : beat_cnt + BEAT_ONE;
  end

  dpe_rr_pick #(
    .N  (NUM_IN),
    .IW ($bits(dpe_src_t))
  ) u_pick (
    .req    (req),
    .start  (pick_start),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Scheduler FSM with registered grant, idle and watchdog outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state     <= SCHED_IDLE;
      grant     <= '0;
      grant_idx <= DPE_SRC_CPU;
      grant_vld <= 1'b0;
      is_idle   <= 1'b1;
      wdog_err  <= 1'b0;
      rr_ptr    <= DPE_SRC_CPU;
      burst_cnt <= '0;
      beat_cnt  <= '0;
    end else begin
      wdog_err <= 1'b0;
      case (state)
        SCHED_IDLE: begin
          // Stray handshakes here are ignored; only a request can leave IDLE.
          if (!pause && pick_any) begin
            grant     <= pick_onehot;
            grant_idx <= pick_idx;
            grant_vld <= 1'b1;
            burst_cnt <= 4'd1;
            beat_cnt  <= '0;
            is_idle   <= 1'b0;
            state     <= SCHED_BUSY;
          end
        end
        SCHED_BUSY: begin
          if (out_hs) begin
            beat_cnt <= beat_inc;
            // beat_cnt only climbs within a packet, so this matches once.
            if (!out_last && beat_inc == BEAT_LIMIT) wdog_err <= 1'b1;
          end
          if (pkt_end) begin
            beat_cnt <= '0;
            if (!pause && owner_req && burst_cnt < BURST_Q) begin
              burst_cnt <= burst_cnt + 4'd1;
            end else if (!pause && pick_any) begin
              // Searching from owner+1 puts the owner last, so it only wins
              // again when nobody else is asking (fresh burst).
              grant     <= pick_onehot;
              grant_idx <= pick_idx;
              burst_cnt <= 4'd1;
              rr_ptr    <= owner_nxt;
            end else begin
              grant     <= '0;
              grant_idx <= DPE_SRC_CPU;
              grant_vld <= 1'b0;
              burst_cnt <= '0;
              rr_ptr    <= owner_nxt;
              is_idle   <= 1'b1;
              state     <= SCHED_IDLE;
            end
          end
        end
        default: state <= SCHED_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dpe_mux_scheduler.sv
// Directed bench for dpe_mux_scheduler. dut_a runs BURST=2 with an 8-beat
// watchdog; dut_b runs BURST=1 for the pure round-robin sequence.
module tb_dpe_mux_scheduler;

  logic       clk;
  logic       rst;
  logic [4:0] req;
  logic       out_hs;
  logic       out_last;
  logic       pause;

  logic [4:0] a_grant;
  logic [2:0] a_grant_idx;
  logic       a_grant_vld;
  logic       a_is_idle;
  logic       a_wdog_err;

  logic [4:0] b_grant;
  logic [2:0] b_grant_idx;
  logic       b_grant_vld;
  logic       b_is_idle;
  logic       b_wdog_err;

  int n_cmp = 0;
  int n_bad = 0;

  dpe_mux_scheduler #(.NUM_IN(5), .BURST(2), .MAX_BEATS(8)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .out_hs    (out_hs),
    .out_last  (out_last),
    .pause     (pause),
    .grant     (a_grant),
    .grant_idx (a_grant_idx),
    .grant_vld (a_grant_vld),
    .is_idle   (a_is_idle),
    .wdog_err  (a_wdog_err)
  );

  dpe_mux_scheduler #(.NUM_IN(5), .BURST(1), .MAX_BEATS(1024)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .out_hs    (out_hs),
    .out_last  (out_last),
    .pause     (pause),
    .grant     (b_grant),
    .grant_idx (b_grant_idx),
    .grant_vld (b_grant_vld),
    .is_idle   (b_is_idle),
    .wdog_err  (b_wdog_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  // Advance one clock and land 1 time unit after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    req      = '0;
    out_hs   = 1'b0;
    out_last = 1'b0;
    pause    = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({a_grant, a_grant_idx, a_grant_vld, a_is_idle, a_wdog_err} !== 11'b00000_000_0_1_0) begin
      n_bad++;
      $display("FAIL reset_a: got %b expected 00000_000_0_1_0",
               {a_grant, a_grant_idx, a_grant_vld, a_is_idle, a_wdog_err});
    end
    n_cmp++;
    if ({b_grant, b_grant_idx, b_grant_vld, b_is_idle, b_wdog_err} !== 11'b00000_000_0_1_0) begin
      n_bad++;
      $display("FAIL reset_b: got %b expected 00000_000_0_1_0",
               {b_grant, b_grant_idx, b_grant_vld, b_is_idle, b_wdog_err});
    end
    // Handshake with nobody granted must be ignored.
    out_hs   = 1'b1;
    out_last = 1'b1;
    cycle();
    out_hs   = 1'b0;
    out_last = 1'b0;
    n_cmp++;
    if ({a_grant, a_grant_vld, a_is_idle} !== 7'b00000_0_1) begin
      n_bad++;
      $display("FAIL idle_hs_ignored: got %b expected 00000_0_1", {a_grant, a_grant_vld, a_is_idle});
    end
  endtask

  task automatic test_single_requester();
    do_reset();
    req = 5'b00100;
    cycle();
    n_cmp++;
    if ({a_grant, a_is_idle} !== 6'b00100_0) begin
      n_bad++;
      $display("FAIL single_first_grant: got %b expected 00100_0", {a_grant, a_is_idle});
    end
    // Three 4-beat packets at full rate: grant must never move or bubble.
    for (int b = 0; b < 12; b++) begin
      out_hs   = 1'b1;
      out_last = (b % 4 == 3);
      cycle();
      n_cmp++;
      if ({a_grant, a_grant_vld, a_is_idle} !== 7'b00100_1_0) begin
        n_bad++;
        $display("FAIL single_beat%0d: got %b expected 00100_1_0", b + 1,
                 {a_grant, a_grant_vld, a_is_idle});
      end
    end
    out_hs   = 1'b0;
    out_last = 1'b0;
  endtask

  task automatic test_all_five();
    logic [2:0] exp_idx;
    do_reset();
    req = 5'b11111;
    cycle();
    // BURST=1: owner rotates every packet, each grant lasting 4 cycles.
    for (int p = 0; p < 6; p++) begin
      exp_idx = 3'(p % 5);
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (b_grant_idx !== exp_idx || b_grant !== (5'b00001 << exp_idx)) begin
          n_bad++;
          $display("FAIL all5_pkt%0d_cyc%0d: got idx %0d grant %b expected idx %0d grant %b",
                   p, k, b_grant_idx, b_grant, exp_idx, 5'b00001 << exp_idx);
        end
        out_hs   = 1'b1;
        out_last = (k == 3);
        cycle();
      end
    end
    out_hs   = 1'b0;
    out_last = 1'b0;
  endtask

  task automatic test_burst_quota();
    logic [2:0] order [6];
    order = '{3'd0, 3'd0, 3'd3, 3'd3, 3'd0, 3'd0};
    do_reset();
    req = 5'b01001;
    cycle();
    for (int p = 0; p < 6; p++) begin
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (a_grant_idx !== order[p] || a_grant_vld !== 1'b1) begin
          n_bad++;
          $display("FAIL burst_pkt%0d_cyc%0d: got idx %0d vld %b expected idx %0d vld 1",
                   p, k, a_grant_idx, a_grant_vld, order[p]);
        end
        out_hs   = 1'b1;
        out_last = (k == 1);
        cycle();
      end
    end
    out_hs   = 1'b0;
    out_last = 1'b0;
  endtask

  task automatic test_pause();
    logic [5:0] hs_pat;
    logic [5:0] last_pat;
    hs_pat   = 6'b111001;  // bit i = cycle i: beat, stall, stall, beat, beat, beat
    last_pat = 6'b100000;
    do_reset();
    req = 5'b00010;
    cycle();
    n_cmp++;
    if (a_grant !== 5'b00010) begin
      n_bad++;
      $display("FAIL pause_grant1: got %b expected 00010", a_grant);
    end
    for (int i = 0; i < 6; i++) begin
      out_hs   = hs_pat[i];
      out_last = last_pat[i];
      pause    = (i >= 1);
      cycle();
      n_cmp++;
      if (i < 5) begin
        if ({a_grant, a_is_idle} !== 6'b00010_0) begin
          n_bad++;
          $display("FAIL pause_inpkt%0d: got %b expected 00010_0", i, {a_grant, a_is_idle});
        end
      end else begin
        if ({a_grant, a_grant_vld, a_is_idle} !== 7'b00000_0_1) begin
          n_bad++;
          $display("FAIL pause_release_idle: got %b expected 00000_0_1",
                   {a_grant, a_grant_vld, a_is_idle});
        end
      end
    end
    out_hs   = 1'b0;
    out_last = 1'b0;
    req      = 5'b11111;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_cmp++;
      if ({a_grant, a_is_idle} !== 6'b00000_1) begin
        n_bad++;
        $display("FAIL pause_hold%0d: got %b expected 00000_1", i, {a_grant, a_is_idle});
      end
    end
    pause = 1'b0;
    cycle();
    n_cmp++;
    if ({a_grant, a_grant_idx, a_is_idle} !== 9'b00100_010_0) begin
      n_bad++;
      $display("FAIL pause_resume: got %b expected 00100_010_0", {a_grant, a_grant_idx, a_is_idle});
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    req = 5'b10000;
    cycle();
    for (int b = 1; b <= 10; b++) begin
      out_hs   = 1'b1;
      out_last = (b == 10);
      if (b == 10) req = 5'b00000;
      cycle();
      n_cmp++;
      if (a_wdog_err !== (b == 8)) begin
        n_bad++;
        $display("FAIL wdog_beat%0d: got %b expected %b", b, a_wdog_err, (b == 8));
      end
      n_cmp++;
      if (a_grant !== ((b < 10) ? 5'b10000 : 5'b00000)) begin
        n_bad++;
        $display("FAIL wdog_grant_beat%0d: got %b expected %b", b, a_grant,
                 (b < 10) ? 5'b10000 : 5'b00000);
      end
    end
    out_hs   = 1'b0;
    out_last = 1'b0;
    cycle();
    n_cmp++;
    if (a_wdog_err !== 1'b0) begin
      n_bad++;
      $display("FAIL wdog_after: got %b expected 0", a_wdog_err);
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    // One single-beat packet from input 0 moves the round-robin pointer to 1.
    req = 5'b00001;
    cycle();
    out_hs   = 1'b1;
    out_last = 1'b1;
    req      = 5'b00000;
    cycle();
    out_hs   = 1'b0;
    out_last = 1'b0;
    n_cmp++;
    if ({a_grant, a_is_idle} !== 6'b00000_1) begin
      n_bad++;
      $display("FAIL rstmid_idle: got %b expected 00000_1", {a_grant, a_is_idle});
    end
    req = 5'b00001;
    cycle();
    n_cmp++;
    if (a_grant !== 5'b00001) begin
      n_bad++;
      $display("FAIL rstmid_grant0: got %b expected 00001", a_grant);
    end
    out_hs = 1'b1;
    cycle();
    rst = 1'b1;
    cycle();
    rst    = 1'b0;
    out_hs = 1'b0;
    n_cmp++;
    if ({a_grant, a_grant_vld, a_is_idle} !== 7'b00000_0_1) begin
      n_bad++;
      $display("FAIL rstmid_drop: got %b expected 00000_0_1", {a_grant, a_grant_vld, a_is_idle});
    end
    req = 5'b00011;
    cycle();
    n_cmp++;
    if ({a_grant, a_grant_idx} !== 8'b00001_000) begin
      n_bad++;
      $display("FAIL rstmid_rrptr: got %b expected 00001_000", {a_grant, a_grant_idx});
    end
  endtask

  initial begin
    rst      = 1'b1;
    req      = '0;
    out_hs   = 1'b0;
    out_last = 1'b0;
    pause    = 1'b0;
    test_reset();
    test_single_requester();
    test_all_five();
    test_burst_quota();
    test_pause();
    test_watchdog();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
